match_ctrl: RTL and testbench

- Game-flow controller for the ping-pong design, sitting directly upstream of the continue-screen block.
- Counts points for both players and detects the match winner, driving `won` to the continue screen.
- Gates ball motion through a serve delay and selects the active screen.
- Consumes the continue screen's `yes`/`no` to restart the match or end the session.

---
 rtl/game_pkg.sv | 33 +++
 rtl/match_ctrl_if.sv | 32 +++
 rtl/match_ctrl_serve_timer.sv | 40 ++++
 rtl/match_ctrl.sv | 143 ++++++++++++++
 tb/tb_match_ctrl.sv | 138 +++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the ping-pong game flow.
// Holds the controller state encoding, the screen_sel codes driven to the
// display mux, and the winner codes read by the continue screen and the
// score display.
package game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3,
        ST_END   = 3'd4
    } state_t;

    localparam logic [1:0] SCR_TITLE = 2'b00;
    localparam logic [1:0] SCR_GAME  = 2'b01;
    localparam logic [1:0] SCR_CONT  = 2'b10;
    localparam logic [1:0] SCR_END   = 2'b11;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    // Screen shown for each controller state (SERVE and PLAY share the game screen).
    function automatic logic [1:0] screen_of(state_t s);
        case (s)
            ST_SERVE, ST_PLAY: screen_of = SCR_GAME;
            ST_OVER:           screen_of = SCR_CONT;
            ST_END:            screen_of = SCR_END;
            default:           screen_of = SCR_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Signal bundle between the match controller and the rest of the game.
//   enter, point_p1, point_p2, yes, no : event pulses into the controller
//   won, screen_sel, score1, score2    : match status out of the controller
//   ball_run, round_reset, cont_reset  : ball/paddle/continue-screen control
// master: the controller side; slave: the surrounding game logic.
interface match_ctrl_if;
    import game_pkg::*;

    logic       enter;
    logic       point_p1;
    logic       point_p2;
    logic       yes;
    logic       no;
    logic       won;
    logic [1:0] screen_sel;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_run;
    logic       round_reset;
    logic       cont_reset;

    modport master (
        input  enter, point_p1, point_p2, yes, no,
        output won, screen_sel, score1, score2, ball_run, round_reset, cont_reset
    );

    modport slave (
        output enter, point_p1, point_p2, yes, no,
        input  won, screen_sel, score1, score2, ball_run, round_reset, cont_reset
    );

endinterface

// File: rtl/match_ctrl_serve_timer.sv
// Serve delay counter.
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : load zero (wins over en_i)
//   en_i       : count up by one
//   done_o     : counter currently holds SERVE_DELAY-1
module serve_timer
    import game_pkg::*;
#(
    parameter int SERVE_DELAY = 100_000_000,
    parameter int SD_W        = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [SD_W-1:0] LAST = SD_W'(SERVE_DELAY - 1);

    logic [SD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + SD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/match_ctrl.sv
// Game-flow controller: title -> serve -> play -> continue/end screens.
// Counts points, detects the winner, holds the ball during the serve delay
// and selects the active screen. All outputs are registered.
//   clk, reset : clock and synchronous active-high reset
//   bus        : match_ctrl_if.master (event pulses in, status/control out)
module match_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int SERVE_DELAY = 100_000_000,
    parameter int SD_W        = 27
) (
    input  logic          clk,
    input  logic          reset,
    match_ctrl_if.master  bus
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       won_q, won_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] screen_q, screen_d;
    logic       ball_run_q, ball_run_d;
    logic       round_reset_q, round_reset_d;
    logic       cont_reset_q, cont_reset_d;
    logic       serve_done;
    logic [3:0] score1_inc, score2_inc;

    // Counter sits at zero outside SERVE, so every SERVE entry starts a full delay.
    serve_timer #(
        .SERVE_DELAY (SERVE_DELAY),
        .SD_W        (SD_W)
    ) u_serve_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q != ST_SERVE) || serve_done),
        .en_i   (1'b1),
        .done_o (serve_done)
    );

    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        won_d         = won_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        round_reset_d = 1'b0;
        cont_reset_d  = 1'b0;

        case (state_q)
            ST_TITLE: begin
                if (bus.enter) begin
                    state_d       = ST_SERVE;
                    score1_d      = '0;
                    score2_d      = '0;
                    round_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (serve_done)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Simultaneous points cancel out; only a lone pulse scores.
                if (bus.point_p1 && !bus.point_p2) begin
                    score1_d = score1_inc;
                    if (score1_inc == WIN) begin
                        state_d      = ST_OVER;
                        won_d        = PLAYER1;
                        cont_reset_d = 1'b1;
                    end else begin
                        state_d       = ST_SERVE;
                        round_reset_d = 1'b1;
                    end
                end else if (bus.point_p2 && !bus.point_p1) begin
                    score2_d = score2_inc;
                    if (score2_inc == WIN) begin
                        state_d      = ST_OVER;
                        won_d        = PLAYER2;
                        cont_reset_d = 1'b1;
                    end else begin
                        state_d       = ST_SERVE;
                        round_reset_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                // cont_reset_q is high only on the first OVER cycle: use it as
                // the entry guard so a stale yes/no cannot skip the screen.
                if (!cont_reset_q) begin
                    if (bus.yes) begin
                        state_d       = ST_SERVE;
                        score1_d      = '0;
                        score2_d      = '0;
                        round_reset_d = 1'b1;
                    end else if (bus.no) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: ;
            default: state_d = ST_TITLE;
        endcase

        ball_run_d = (state_d == ST_PLAY);
        screen_d   = screen_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_TITLE;
            won_q         <= 1'b0;
            score1_q      <= '0;
            score2_q      <= '0;
            screen_q      <= SCR_TITLE;
            ball_run_q    <= 1'b0;
            round_reset_q <= 1'b0;
            cont_reset_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            won_q         <= won_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            screen_q      <= screen_d;
            ball_run_q    <= ball_run_d;
            round_reset_q <= round_reset_d;
            cont_reset_q  <= cont_reset_d;
        end
    end

    assign bus.won         = won_q;
    assign bus.screen_sel  = screen_q;
    assign bus.score1      = score1_q;
    assign bus.score2      = score2_q;
    assign bus.ball_run    = ball_run_q;
    assign bus.round_reset = round_reset_q;
    assign bus.cont_reset  = cont_reset_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with SERVE_DELAY = 4, WIN_SCORE = 3.
// Each step drives one cycle of inputs, queues the outputs expected after
// the next rising edge, then pops and compares them 1 ns after that edge.
module tb_match_ctrl;

    typedef struct packed {
        logic [1:0] scr;
        logic       won;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       br;
        logic       rr;
        logic       cr;
    } exp_t;

    // input pattern bits: enter, p1, p2, yes, no, reset
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] ENT  = 6'b100000;
    localparam logic [5:0] P1   = 6'b010000;
    localparam logic [5:0] P2   = 6'b001000;
    localparam logic [5:0] YES  = 6'b000100;
    localparam logic [5:0] NO   = 6'b000010;
    localparam logic [5:0] RST  = 6'b000001;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   step_no = 0;
    exp_t sb[$];

    match_ctrl_if bus();

    match_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_DELAY (4),
        .SD_W        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL step %0d %s: observed %0h expected %0h", step_no, tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] in, input logic [1:0] scr, input logic w,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic br, input logic rr, input logic cr);
        exp_t e;
        bus.enter    = in[5];
        bus.point_p1 = in[4];
        bus.point_p2 = in[3];
        bus.yes      = in[2];
        bus.no       = in[1];
        reset        = in[0];
        sb.push_back('{scr, w, s1, s2, br, rr, cr});
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        cmp("screen_sel",  {2'b00, bus.screen_sel}, {2'b00, e.scr});
        cmp("won",         {3'b000, bus.won},         {3'b000, e.won});
        cmp("score1",      bus.score1,                e.s1);
        cmp("score2",      bus.score2,                e.s2);
        cmp("ball_run",    {3'b000, bus.ball_run},    {3'b000, e.br});
        cmp("round_reset", {3'b000, bus.round_reset}, {3'b000, e.rr});
        cmp("cont_reset",  {3'b000, bus.cont_reset},  {3'b000, e.cr});
    endtask

    // Called after the step that entered SERVE: three held cycles, then PLAY.
    task automatic serve_wait(input logic [5:0] first, input logic w,
                              input logic [3:0] s1, input logic [3:0] s2);
        step(first, 2'b01, w, s1, s2, 1'b0, 1'b0, 1'b0);
        step(NONE,  2'b01, w, s1, s2, 1'b0, 1'b0, 1'b0);
        step(NONE,  2'b01, w, s1, s2, 1'b0, 1'b0, 1'b0);
        step(NONE,  2'b01, w, s1, s2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        step(RST,  2'b00, 0, 0, 0, 0, 0, 0);
        step(NONE, 2'b00, 0, 0, 0, 0, 0, 0);
        // title -> serve, ball released 4 cycles later; yes/p1 ignored in title
        step(YES | P1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(ENT,  2'b01, 0, 0, 0, 0, 1, 0);
        serve_wait(NONE, 0, 0, 0);
        // player 2 wins 3-0
        step(P2, 2'b01, 0, 0, 1, 0, 1, 0);
        serve_wait(NONE, 0, 0, 1);
        step(P2, 2'b01, 0, 0, 2, 0, 1, 0);
        serve_wait(NONE, 0, 0, 2);
        step(P2, 2'b10, 1, 0, 3, 0, 0, 1);
        // entry-cycle guard, then yes+no together -> yes wins
        step(YES,      2'b10, 1, 0, 3, 0, 0, 0);
        step(NONE,     2'b10, 1, 0, 3, 0, 0, 0);
        step(YES | NO, 2'b01, 1, 0, 0, 0, 1, 0);
        // point during serve ignored
        serve_wait(P1, 1, 0, 0);
        // simultaneous points discarded, stays in PLAY; enter ignored
        step(P1 | P2, 2'b01, 1, 0, 0, 1, 0, 0);
        step(ENT,     2'b01, 1, 0, 0, 1, 0, 0);
        // player 1 wins 3-0
        step(P1, 2'b01, 1, 1, 0, 0, 1, 0);
        serve_wait(NONE, 1, 1, 0);
        step(P1, 2'b01, 1, 2, 0, 0, 1, 0);
        serve_wait(NONE, 1, 2, 0);
        step(P1, 2'b10, 0, 3, 0, 0, 0, 1);
        step(NONE, 2'b10, 0, 3, 0, 0, 0, 0);
        // quit -> END, terminal
        step(NO,   2'b11, 0, 3, 0, 0, 0, 0);
        step(ENT,  2'b11, 0, 3, 0, 0, 0, 0);
        step(YES,  2'b11, 0, 3, 0, 0, 0, 0);
        step(P1,   2'b11, 0, 3, 0, 0, 0, 0);
        step(P2,   2'b11, 0, 3, 0, 0, 0, 0);
        step(RST,  2'b00, 0, 0, 0, 0, 0, 0);
        // reset mid-serve (counter = 2) together with a point
        step(ENT,      2'b01, 0, 0, 0, 0, 1, 0);
        step(NONE,     2'b01, 0, 0, 0, 0, 0, 0);
        step(NONE,     2'b01, 0, 0, 0, 0, 0, 0);
        step(RST | P1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(NONE,     2'b00, 0, 0, 0, 0, 0, 0);
        // full serve delay again after the reset
        step(ENT, 2'b01, 0, 0, 0, 0, 1, 0);
        serve_wait(NONE, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
